fetch_unit: RTL and testbench

Parametrised instruction-fetch stage: owns the fetch PC, reads a synchronous-read instruction memory, and presents instruction/PC pairs to decode over a valid/ready handshake, buffered in a small FIFO so decode stalls never drop or duplicate an instruction. Supports redirect (branch/jump target) with flush of all in-flight and buffered fetches, and flags misaligned and out-of-range fetch addresses instead of reading memory. Sits between the PC/branch logic and decode; replaces the single-register fetch with a pipelined, stallable front end.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: fault codes and the
// instruction/pc/fault entry carried from fetch to decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        fault_e      fault;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{instr: 32'h0, pc: 32'h0, fault: FAULT_NONE};

endpackage

// File: rtl/fetch_fifo.sv
// Output buffer of fetch entries between the fetch pipeline and decode.
// Flush drops every buffered entry; the head slot keeps its stale contents.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           do_push;
    logic           do_pop;

    // Guard against underflow and overflow even if the producer misbehaves.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: PC register, synchronous-read instruction memory,
// one in-flight slot and an output FIFO with credit-based issue and redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned NUM_INSTR  = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned AW = $clog2(NUM_INSTR),
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output fault_e        out_fault
);

    logic [31:0]   mem [NUM_INSTR];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halt_q, halt_d;
    logic          infl_valid_q, infl_valid_d;
    fetch_entry_t  infl_q, infl_d;

    fetch_entry_t  fifo_head;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          issue;
    logic [CW:0]   occupancy;
    fault_e        issue_fault;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Credit check: everything buffered or in flight after this edge must fit.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(infl_valid_q) - (CW+1)'(pop);
    assign issue     = !halt_q && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        issue_fault = FAULT_NONE;
        if (fetch_pc_q[1:0] != 2'b00) begin
            issue_fault = FAULT_MISALIGN;
        end else if (32'(fetch_pc_q[31:2]) >= NUM_INSTR) begin
            issue_fault = FAULT_RANGE;
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        halt_d       = halt_q;
        infl_valid_d = 1'b0;
        infl_d       = infl_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halt_d     = 1'b0;
        end else if (issue) begin
            infl_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            infl_d.pc    = fetch_pc_q;
            infl_d.fault = issue_fault;
            infl_d.instr = (issue_fault == FAULT_NONE) ? mem[fetch_pc_q[AW+1:2]] : NOP_INSTR;
            // A faulting fetch is the last one until software redirects.
            if (issue_fault != FAULT_NONE) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            halt_q       <= 1'b0;
            infl_valid_q <= 1'b0;
            infl_q       <= RESET_ENTRY;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            halt_q       <= halt_d;
            infl_valid_q <= infl_valid_d;
            infl_q       <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we && (32'(imem_waddr) < NUM_INSTR)) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_valid_q),
        .push_data_i (infl_q),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;
    assign out_fault = fifo_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance for streaming, stall, redirect,
// misalign and reset; a small-memory instance for the range-fault boundary.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    int          checks;
    int          failures;

    // Instance 0: default parameters
    logic        rst0, we0, redir0, ready0;
    logic [9:0]  waddr0;
    logic [31:0] wdata0, rpc0;
    logic        o0_valid;
    logic [31:0] o0_instr, o0_pc;
    fault_e      o0_fault;

    // Instance 1: last word of a 16-word memory as reset PC
    logic        rst1, we1, redir1, ready1;
    logic [3:0]  waddr1;
    logic [31:0] wdata1, rpc1;
    logic        o1_valid;
    logic [31:0] o1_instr, o1_pc;
    fault_e      o1_fault;

    fetch_unit u0 (
        .clk(clk), .rst(rst0), .imem_we(we0), .imem_waddr(waddr0), .imem_wdata(wdata0),
        .redirect_valid(redir0), .redirect_pc(rpc0), .out_valid(o0_valid), .out_ready(ready0),
        .out_instr(o0_instr), .out_pc(o0_pc), .out_fault(o0_fault)
    );

    fetch_unit #(.NUM_INSTR(16), .RESET_PC(32'd60), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst1), .imem_we(we1), .imem_waddr(waddr1), .imem_wdata(wdata1),
        .redirect_valid(redir1), .redirect_pc(rpc1), .out_valid(o1_valid), .out_ready(ready1),
        .out_instr(o1_instr), .out_pc(o1_pc), .out_fault(o1_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [1:0] flt);
        chk({tag, ".valid"}, 32'(o0_valid), 32'(v));
        chk({tag, ".pc"},    o0_pc,    pc);
        chk({tag, ".instr"}, o0_instr, instr);
        chk({tag, ".fault"}, 32'(o0_fault), 32'(flt));
    endtask

    task automatic chk1(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [1:0] flt);
        chk({tag, ".valid"}, 32'(o1_valid), 32'(v));
        chk({tag, ".pc"},    o1_pc,    pc);
        chk({tag, ".instr"}, o1_instr, instr);
        chk({tag, ".fault"}, 32'(o1_fault), 32'(flt));
    endtask

    function automatic logic [31:0] word0(input int i);
        return (i < 4) ? 32'(11 * (i + 1)) : 32'h1000 + 32'(i);
    endfunction

    initial begin
        checks = 0; failures = 0;
        rst0 = 1'b1; we0 = 1'b0; waddr0 = '0; wdata0 = '0; redir0 = 1'b0; rpc0 = '0; ready0 = 1'b1;
        rst1 = 1'b1; we1 = 1'b0; waddr1 = '0; wdata1 = '0; redir1 = 1'b0; rpc1 = '0; ready1 = 1'b1;

        // Preload both memories while held in reset
        for (int i = 0; i < 32; i++) begin
            we0 = 1'b1; waddr0 = 10'(i); wdata0 = word0(i);
            we1 = (i < 16); waddr1 = 4'(i); wdata1 = 32'hABCD_0000 + 32'(i);
            tick();
        end
        we0 = 1'b0; we1 = 1'b0;
        chk0("reset", 1'b0, 32'h0, 32'h0, 2'b00);

        // Streaming from RESET_PC: first valid after edge 2, one per cycle
        rst0 = 1'b0;
        tick();
        chk("stream_e1_valid", 32'(o0_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk0("stream", 1'b1, 32'(4 * k), word0(k), 2'b00);
        end

        // Redirect to 0 then stall decode for 5 cycles from first valid
        redir0 = 1'b1; rpc0 = 32'h0; ready0 = 1'b0;
        tick();
        chk("redir0_e0_valid", 32'(o0_valid), 32'd0);
        redir0 = 1'b0;
        tick();
        chk("redir0_e1_valid", 32'(o0_valid), 32'd0);
        tick();
        chk0("stall_first", 1'b1, 32'h0, 32'd11, 2'b00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk0("stall_hold", 1'b1, 32'h0, 32'd11, 2'b00);
        end
        chk("stall_count", 32'(u0.u_fifo.count_q), 32'd2);
        ready0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk0("stall_release", 1'b1, 32'(4 * k), word0(k), 2'b00);
        end

        // Fill FIFO, then redirect to 0x40
        ready0 = 1'b0;
        tick();
        chk0("full_hold", 1'b1, 32'd16, word0(4), 2'b00);
        tick();
        chk("full_count", 32'(u0.u_fifo.count_q), 32'd2);
        redir0 = 1'b1; rpc0 = 32'h40;
        tick();
        chk("redir40_e0_valid", 32'(o0_valid), 32'd0);
        redir0 = 1'b0;
        tick();
        chk("redir40_e1_valid", 32'(o0_valid), 32'd0);
        tick();
        chk0("redir40_e2", 1'b1, 32'h40, 32'h1010, 2'b00);

        // Misaligned redirect: single NOP entry with fault, then halt
        ready0 = 1'b1; redir0 = 1'b1; rpc0 = 32'h42;
        tick();
        chk("mis_e0_valid", 32'(o0_valid), 32'd0);
        redir0 = 1'b0;
        tick();
        chk("mis_e1_valid", 32'(o0_valid), 32'd0);
        tick();
        chk0("mis_entry", 1'b1, 32'h42, 32'h13, 2'b01);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mis_halted_valid", 32'(o0_valid), 32'd0);
        end
        redir0 = 1'b1; rpc0 = 32'h0;
        tick();
        redir0 = 1'b0;
        tick();
        chk("resume_e1_valid", 32'(o0_valid), 32'd0);
        tick();
        chk0("resume", 1'b1, 32'h0, 32'd11, 2'b00);

        // Async reset with entries buffered
        ready0 = 1'b0;
        tick();
        tick();
        chk("pre_rst_count", 32'(u0.u_fifo.count_q), 32'd2);
        #2;
        rst0 = 1'b1;
        #1;
        chk0("async_rst", 1'b0, 32'h0, 32'h0, 2'b00);
        tick();
        rst0 = 1'b0; ready0 = 1'b1;
        tick();
        chk("rst_e1_valid", 32'(o0_valid), 32'd0);
        tick();
        chk0("rst_restart0", 1'b1, 32'h0, 32'd11, 2'b00);
        tick();
        chk0("rst_restart1", 1'b1, 32'h4, 32'd22, 2'b00);

        // Range boundary: last valid word then out-of-range fault, then halt
        rst1 = 1'b0;
        tick();
        chk("rng_e1_valid", 32'(o1_valid), 32'd0);
        tick();
        chk1("rng_last", 1'b1, 32'd60, 32'hABCD_000F, 2'b00);
        tick();
        chk1("rng_fault", 1'b1, 32'd64, 32'h13, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rng_halted_valid", 32'(o1_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
